// File: rtl/armleocpu_alu_wb_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : armleocpu_defs (package)
// Description : Shared widths for the ALU writeback buffer slice: datapath
//               width and register-file index width.
// Revision    : 1.0 - initial release
// ============================================================================
package armleocpu_defs;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;

endpackage : armleocpu_defs
`default_nettype wire

// File: rtl/armleocpu_alu_wb_buffer_fwd_lookup.sv
`default_nettype none
// ============================================================================
// Module      : armleocpu_fwd_lookup
// Description : Youngest-first register match over DEPTH buffered entries.
//               Entries arrive ordered by age, slot 0 being the oldest, so a
//               plain ascending scan lets younger matches overwrite older ones.
// Revision    : 1.0 - initial release
// ============================================================================
module armleocpu_fwd_lookup
  import armleocpu_defs::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int DEPTH  = 2
) (
  input  logic [DEPTH-1:0]        ent_valid,
  input  logic [DEPTH*REG_W-1:0]  ent_rd,
  input  logic [DEPTH*XLEN_P-1:0] ent_data,
  input  logic [DEPTH-1:0]        ent_illegal,
  input  logic [REG_W-1:0]        addr,
  output logic                    hit,
  output logic [XLEN_P-1:0]       data
);

  // Ascending age scan: the last (youngest) qualifying entry wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_valid[k] && !ent_illegal[k] && (addr != '0) &&
          (ent_rd[k*REG_W +: REG_W] == addr)) begin
        hit  = 1'b1;
        data = ent_data[k*XLEN_P +: XLEN_P];
      end
    end
  end

endmodule : armleocpu_fwd_lookup
`default_nettype wire

// File: rtl/armleocpu_alu_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : armleocpu_alu_wb_buffer
// Description : Registered execute-to-writeback FIFO behind the ALU. Holds
//               result, rd, PC and illegal flag per entry, retires in order
//               over a valid/ready port and forwards in-flight results.
// Revision    : 1.0 - initial release
// ============================================================================
module armleocpu_alu_wb_buffer
  import armleocpu_defs::*;
#(
  parameter int XLEN_P = XLEN,
  parameter int DEPTH  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,

  input  logic                     e2w_valid,
  output logic                     e2w_ready,
  input  logic [XLEN_P-1:0]        e2w_pc,
  input  logic [REG_W-1:0]         e2w_rd,
  input  logic [XLEN_P-1:0]        e2w_result,
  input  logic                     e2w_illegal,

  output logic                     w_valid,
  input  logic                     w_ready,
  output logic [XLEN_P-1:0]        w_pc,
  output logic [REG_W-1:0]         w_rd,
  output logic [XLEN_P-1:0]        w_wdata,
  output logic                     w_write,
  output logic                     w_trap,

  input  logic [REG_W-1:0]         fwd_rs1_addr,
  output logic                     fwd_rs1_hit,
  output logic [XLEN_P-1:0]        fwd_rs1_data,
  input  logic [REG_W-1:0]         fwd_rs2_addr,
  output logic                     fwd_rs2_hit,
  output logic [XLEN_P-1:0]        fwd_rs2_data,

  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Occupancy and pointer state
  logic [CNT_W-1:0] count_q,  count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

  // Payload storage, intentionally not reset
  logic [XLEN_P-1:0] pc_mem_q      [DEPTH];
  logic [REG_W-1:0]  rd_mem_q      [DEPTH];
  logic [XLEN_P-1:0] result_mem_q  [DEPTH];
  logic              illegal_mem_q [DEPTH];

  logic push;
  logic pop;

  // Handshake: ready depends on state only, flush vetoes the push
  always_comb begin
    e2w_ready = !rst && (count_q < DEPTH_C);
    w_valid   = (count_q != '0);
    push      = e2w_valid && e2w_ready && !flush;
    pop       = w_valid && w_ready;
  end

  // Next-state for occupancy and pointers; reset over flush over push/pop
  always_comb begin
    count_d  = count_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (rst) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else if (flush) begin
      count_d  = '0;
      rd_ptr_d = wr_ptr_q;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // Control state register
  always_ff @(posedge clk) begin
    count_q  <= count_d;
    rd_ptr_q <= rd_ptr_d;
    wr_ptr_q <= wr_ptr_d;
  end

  // Payload write at the tail on an accepted push
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]      <= e2w_pc;
      rd_mem_q[wr_ptr_q]      <= e2w_rd;
      result_mem_q[wr_ptr_q]  <= e2w_result;
      illegal_mem_q[wr_ptr_q] <= e2w_illegal;
    end
  end

  // Head presentation; qualifiers gated by w_valid so idle state is clean
  always_comb begin
    w_pc    = pc_mem_q[rd_ptr_q];
    w_rd    = rd_mem_q[rd_ptr_q];
    w_wdata = result_mem_q[rd_ptr_q];
    w_trap  = w_valid && illegal_mem_q[rd_ptr_q];
    w_write = w_valid && !illegal_mem_q[rd_ptr_q] && (rd_mem_q[rd_ptr_q] != '0);
    count   = count_q;
  end

  // Re-order storage by age (slot 0 = head/oldest) for the lookup units
  logic [DEPTH-1:0]        age_valid;
  logic [DEPTH*REG_W-1:0]  age_rd;
  logic [DEPTH*XLEN_P-1:0] age_data;
  logic [DEPTH-1:0]        age_illegal;

  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    logic [PTR_W-1:0] slot;
    assign slot                            = rd_ptr_q + PTR_W'(k);
    assign age_valid[k]                    = (CNT_W'(k) < count_q);
    assign age_rd[k*REG_W +: REG_W]        = rd_mem_q[slot];
    assign age_data[k*XLEN_P +: XLEN_P]    = result_mem_q[slot];
    assign age_illegal[k]                  = illegal_mem_q[slot];
  end

  armleocpu_fwd_lookup #(
    .XLEN_P (XLEN_P),
    .DEPTH  (DEPTH)
  ) u_fwd_rs1 (
    .ent_valid   (age_valid),
    .ent_rd      (age_rd),
    .ent_data    (age_data),
    .ent_illegal (age_illegal),
    .addr        (fwd_rs1_addr),
    .hit         (fwd_rs1_hit),
    .data        (fwd_rs1_data)
  );

  armleocpu_fwd_lookup #(
    .XLEN_P (XLEN_P),
    .DEPTH  (DEPTH)
  ) u_fwd_rs2 (
    .ent_valid   (age_valid),
    .ent_rd      (age_rd),
    .ent_data    (age_data),
    .ent_illegal (age_illegal),
    .addr        (fwd_rs2_addr),
    .hit         (fwd_rs2_hit),
    .data        (fwd_rs2_data)
  );

endmodule : armleocpu_alu_wb_buffer
`default_nettype wire

// File: tb/tb_armleocpu_alu_wb_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_armleocpu_alu_wb_buffer
// Description : Scoreboard bench for the ALU writeback buffer. Directed
//               pushes enqueue hand-computed expected retirements; a monitor
//               compares every handshaked head against the queue front.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_armleocpu_alu_wb_buffer;

  typedef struct {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        write;
    logic        trap;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        e2w_valid;
  logic        e2w_ready;
  logic [31:0] e2w_pc;
  logic [4:0]  e2w_rd;
  logic [31:0] e2w_result;
  logic        e2w_illegal;
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_pc;
  logic [4:0]  w_rd;
  logic [31:0] w_wdata;
  logic        w_write;
  logic        w_trap;
  logic [4:0]  fwd_rs1_addr;
  logic        fwd_rs1_hit;
  logic [31:0] fwd_rs1_data;
  logic [4:0]  fwd_rs2_addr;
  logic        fwd_rs2_hit;
  logic [31:0] fwd_rs2_data;
  logic [1:0]  count;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  armleocpu_alu_wb_buffer #(.XLEN_P(32), .DEPTH(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .e2w_valid    (e2w_valid),
    .e2w_ready    (e2w_ready),
    .e2w_pc       (e2w_pc),
    .e2w_rd       (e2w_rd),
    .e2w_result   (e2w_result),
    .e2w_illegal  (e2w_illegal),
    .w_valid      (w_valid),
    .w_ready      (w_ready),
    .w_pc         (w_pc),
    .w_rd         (w_rd),
    .w_wdata      (w_wdata),
    .w_write      (w_write),
    .w_trap       (w_trap),
    .fwd_rs1_addr (fwd_rs1_addr),
    .fwd_rs1_hit  (fwd_rs1_hit),
    .fwd_rs1_data (fwd_rs1_data),
    .fwd_rs2_addr (fwd_rs2_addr),
    .fwd_rs2_hit  (fwd_rs2_hit),
    .fwd_rs2_data (fwd_rs2_data),
    .count        (count)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a push and record its expected retirement.
  task automatic drive_push(input logic [31:0] pc, input logic [4:0] rd,
                            input logic [31:0] res, input logic ill, input bit expect_accept);
    exp_t e;
    e2w_valid   = 1'b1;
    e2w_pc      = pc;
    e2w_rd      = rd;
    e2w_result  = res;
    e2w_illegal = ill;
    if (expect_accept) begin
      e.pc    = pc;
      e.rd    = rd;
      e.data  = res;
      e.trap  = ill;
      e.write = !ill && (rd != 5'd0);
      sb.push_back(e);
    end
  endtask

  // Monitor: every handshaked head must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && w_valid && w_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_retire actual=rd%0d/%0h required=none", w_rd, w_wdata);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("w_pc",    64'(w_pc),    64'(e.pc));
        chk("w_rd",    64'(w_rd),    64'(e.rd));
        chk("w_wdata", 64'(w_wdata), 64'(e.data));
        chk("w_write", 64'(w_write), 64'(e.write));
        chk("w_trap",  64'(w_trap),  64'(e.trap));
      end
    end
  end

  initial begin
    rst = 1'b1; flush = 1'b0; e2w_valid = 1'b0; e2w_pc = '0; e2w_rd = '0;
    e2w_result = '0; e2w_illegal = 1'b0; w_ready = 1'b0;
    fwd_rs1_addr = '0; fwd_rs2_addr = '0;

    // Reset then idle
    tick();
    chk("ready_in_reset0", 64'(e2w_ready), 64'd0);
    tick();
    chk("ready_in_reset1", 64'(e2w_ready), 64'd0);
    rst = 1'b0;
    #1;
    chk("rst_count",   64'(count),       64'd0);
    chk("rst_w_valid", 64'(w_valid),     64'd0);
    chk("rst_w_write", 64'(w_write),     64'd0);
    chk("rst_w_trap",  64'(w_trap),      64'd0);
    chk("rst_ready",   64'(e2w_ready),   64'd1);
    chk("rst_hit1",    64'(fwd_rs1_hit), 64'd0);
    chk("rst_hit2",    64'(fwd_rs2_hit), 64'd0);

    // Single pass with forwarding of the entry being popped
    w_ready = 1'b1;
    drive_push(32'h100, 5'd5, 32'h1234_5678, 1'b0, 1'b1);
    chk("sp_no_bypass", 64'(w_valid), 64'd0);
    tick();
    e2w_valid = 1'b0;
    fwd_rs1_addr = 5'd5;
    #1;
    chk("sp_count1",   64'(count),        64'd1);
    chk("sp_fwd_hit",  64'(fwd_rs1_hit),  64'd1);
    chk("sp_fwd_data", 64'(fwd_rs1_data), 64'h1234_5678);
    tick();
    chk("sp_count0",   64'(count),        64'd0);
    chk("sp_fwd_gone", 64'(fwd_rs1_hit),  64'd0);

    // Backpressure / full
    w_ready = 1'b0;
    drive_push(32'h200, 5'd1, 32'hA, 1'b0, 1'b1);
    tick();
    drive_push(32'h204, 5'd2, 32'hB, 1'b0, 1'b1);
    tick();
    drive_push(32'h208, 5'd4, 32'hC, 1'b0, 1'b0);
    chk("full_count", 64'(count),     64'd2);
    chk("full_ready", 64'(e2w_ready), 64'd0);
    chk("full_head",  64'(w_wdata),   64'hA);
    tick();
    chk("full_count_hold", 64'(count), 64'd2);
    e2w_valid = 1'b0;
    w_ready = 1'b1;
    #1;
    chk("full_ready_with_pop", 64'(e2w_ready), 64'd0);
    tick();
    chk("drain_count1", 64'(count),     64'd1);
    chk("drain_ready",  64'(e2w_ready), 64'd1);
    tick();
    chk("drain_count0", 64'(count),     64'd0);

    // Forwarding priority
    w_ready = 1'b0;
    drive_push(32'h400, 5'd7, 32'h11, 1'b0, 1'b1);
    tick();
    drive_push(32'h404, 5'd7, 32'h22, 1'b0, 1'b1);
    tick();
    e2w_valid = 1'b0;
    fwd_rs1_addr = 5'd7;
    fwd_rs2_addr = 5'd0;
    #1;
    chk("prio_hit",  64'(fwd_rs1_hit),  64'd1);
    chk("prio_data", 64'(fwd_rs1_data), 64'h22);
    w_ready = 1'b1;
    tick();
    w_ready = 1'b0;
    drive_push(32'h408, 5'd0, 32'h33, 1'b0, 1'b1);
    tick();
    e2w_valid = 1'b0;
    #1;
    chk("x0_count",     64'(count),        64'd2);
    chk("x0_rs1_data",  64'(fwd_rs1_data), 64'h22);
    chk("x0_rs2_hit",   64'(fwd_rs2_hit),  64'd0);
    chk("x0_rs2_data",  64'(fwd_rs2_data), 64'h0);
    w_ready = 1'b1;
    tick();
    drive_push(32'h40C, 5'd9, 32'h44, 1'b0, 1'b1);
    tick();
    e2w_valid = 1'b0;
    chk("pushpop_count", 64'(count), 64'd1);
    tick();
    chk("pushpop_drain", 64'(count), 64'd0);

    // Illegal entry
    w_ready = 1'b0;
    drive_push(32'h300, 5'd3, 32'hDEAD, 1'b1, 1'b1);
    tick();
    e2w_valid = 1'b0;
    fwd_rs1_addr = 5'd3;
    #1;
    chk("ill_trap",  64'(w_trap),      64'd1);
    chk("ill_write", 64'(w_write),     64'd0);
    chk("ill_fwd",   64'(fwd_rs1_hit), 64'd0);
    w_ready = 1'b1;
    tick();
    w_ready = 1'b0;

    // Flush with simultaneous push and pop on a full buffer
    drive_push(32'h500, 5'd10, 32'h55, 1'b0, 1'b1);
    tick();
    drive_push(32'h504, 5'd11, 32'h66, 1'b0, 1'b1);
    tick();
    chk("fl_count2", 64'(count), 64'd2);
    drive_push(32'h508, 5'd12, 32'h77, 1'b0, 1'b0);
    w_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    e2w_valid = 1'b0;
    sb.delete();
    chk("fl_count0", 64'(count),   64'd0);
    chk("fl_valid0", 64'(w_valid), 64'd0);
    tick();
    chk("fl_stay_empty", 64'(count), 64'd0);

    // Flush drops a push that the buffer could otherwise accept
    w_ready = 1'b0;
    drive_push(32'h600, 5'd13, 32'h88, 1'b0, 1'b1);
    tick();
    drive_push(32'h604, 5'd14, 32'h99, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    e2w_valid = 1'b0;
    sb.delete();
    chk("fl2_count0", 64'(count), 64'd0);
    fwd_rs1_addr = 5'd14;
    #1;
    chk("fl2_fwd", 64'(fwd_rs1_hit), 64'd0);
    w_ready = 1'b1;
    tick();
    tick();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_armleocpu_alu_wb_buffer
`default_nettype wire

// File: doc/armleocpu_alu_wb_buffer.md
Name: armleocpu_alu_wb_buffer

Overview:
- Registered execute-to-writeback stage, directly downstream of the combinational ALU.
- Captures each ALU result with its destination register, PC and illegal-instruction flag into a small FIFO (a skid buffer at default depth).
- Presents entries in order to the register-file writeback/trap port through a valid/ready handshake.
- Provides combinational operand forwarding of in-flight results to the issue logic.

Parameters:
- XLEN, 32, data/PC width.
- DEPTH, 2, entry count; power of two, >= 2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all buffered entries (branch/trap redirect).
- e2w_valid  in  1  ALU output valid.
- e2w_ready  out  1  buffer can accept an entry.
- e2w_pc  in  XLEN  PC of the instruction.
- e2w_rd  in  5  destination register index.
- e2w_result  in  XLEN  ALU result.
- e2w_illegal  in  1  ALU illegal_instruction flag.
- w_valid  out  1  head entry valid.
- w_ready  in  1  writeback consumes head.
- w_pc  out  XLEN  head PC.
- w_rd  out  5  head rd.
- w_wdata  out  XLEN  head result.
- w_write  out  1  head writes regfile: rd != 0 and not illegal.
- w_trap  out  1  head is an illegal instruction.
- fwd_rs1_addr  in  5  issue-stage rs1 index.
- fwd_rs1_hit  out  1  rs1 value available from buffer.
- fwd_rs1_data  out  XLEN  forwarded rs1 value.
- fwd_rs2_addr  in  5  issue-stage rs2 index.
- fwd_rs2_hit  out  1  rs2 value available from buffer.
- fwd_rs2_data  out  XLEN  forwarded rs2 value.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset: next edge sets count=0 and rd/wr pointers=0. While rst is high, e2w_ready=0 and pushes are ignored. After reset, w_valid=0, w_write=0, w_trap=0 and both fwd hits are 0. Payload storage is not reset; w_* payload outputs are don't-care while w_valid=0.
- Handshake signals:
  - push = e2w_valid & e2w_ready & !flush.
  - pop = w_valid & w_ready.
  - e2w_ready = !rst & (count < DEPTH). It depends on state only; there is no combinational path from w_ready.
- Full buffer: when count==DEPTH, e2w_ready=0 even if pop occurs that cycle.
- Latency: an entry pushed at edge N is visible on w_* after edge N, i.e. 1 cycle minimum. No bypass from e2w_* to w_*.
- Output: w_valid = (count != 0). The head is driven from storage at rd_ptr. w_* payload and rd_ptr are stable while w_valid & !w_ready.
- Ordering and occupancy:
  - Strict FIFO order.
  - Pointers wrap modulo DEPTH.
  - push & pop in the same cycle leaves count unchanged.
  - push alone increments count; pop alone decrements it.
- Flush:
  - Next edge sets count=0 and rd_ptr=wr_ptr.
  - Flush dominates push (input dropped; upstream must not rely on acceptance).
  - A pop in the flush cycle counts as consumed by downstream.
  - Flush has no effect during rst.
- Illegal entries: retire in order with w_trap=1, w_write=0. The buffer does not self-flush; the trap handler asserts flush.
- rd == 0: the entry still occupies a slot and handshakes, with w_write=0.
- Forwarding (combinational):
  - Search all valid entries, youngest first.
  - hit = matching rd, rd != 0, entry not illegal.
  - data is that entry's result; data is 0 when there is no hit.
  - Index 0 never hits.
  - An entry popped this cycle still forwards this cycle.

Decomposition:
- Shared package armleocpu_defs: XLEN and the regfile index width (5).
- One natural sub-module: armleocpu_fwd_lookup, a parameterised youngest-first match over DEPTH entries, instantiated twice (rs1, rs2).

Test Plan:
- Reset then idle: rst high 2 cycles -> e2w_ready=0 during reset; after release count=0, w_valid=0, e2w_ready=1, fwd hits 0.
- Single pass: push rd=5, result=0x1234_5678, pc=0x100, w_ready=1 -> next cycle w_valid=1, w_rd=5, w_wdata=0x12345678, w_write=1; count returns to 0 after pop.
- Backpressure/full: w_ready=0, push 0xA then 0xB -> count=2, e2w_ready=0, third push ignored. Then w_ready=1 -> 0xA then 0xB retire in order; e2w_ready=1 again only after count drops.
- Forwarding priority: buffer holds rd=7 (0x11, older) and rd=7 (0x22, younger); fwd_rs1_addr=7 -> hit=1, data=0x22. fwd_rs2_addr=0 with an rd=0 entry present -> hit=0.
- Illegal: push e2w_illegal=1, rd=3, result=0xDEAD -> w_trap=1, w_write=0; fwd addr 3 -> no hit.
- Flush with simultaneous push and pop: count=2, w_ready=1, flush=1, e2w_valid=1 -> next cycle count=0, w_valid=0, the pushed entry never appears.
